// File: rtl/cc_demux_router.sv
// One-word-per-channel demux router: routes an input word to one of 2**DATAWIDTH_MUX_SELECTION slots.
// Optional macro CC_DEMUX_BROADCAST_EN adds a broadcast input that writes all slots at once.

module cc_demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         load,
    input  logic         ack,
    input  logic [W-1:0] dataIn,
    output logic [W-1:0] dataOut,
    output logic         full
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slotState_t;
    slotState_t state, stateNext;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= EMPTY;
        else       state <= stateNext;
    end

    // load while FULL only happens with ack set, so the slot stays FULL with the new word
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: if (load)        stateNext = FULL;
            FULL:  if (ack && !load) stateNext = EMPTY;
            default:                stateNext = EMPTY;
        endcase
    end

    always_comb begin
        full = (state == FULL);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)     dataOut <= '0;
        else if (load) dataOut <= dataIn;
    end
endmodule

module cc_demux_router #(
    parameter int DATAWIDTH_MUX_SELECTION = 3,
    parameter int DATAWIDTH_BUS           = 8
) (
    input  logic                               CC_DEMUX_CLOCK_50,
    input  logic                               CC_DEMUX_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
    input  logic                               CC_DEMUX_valid_In,
`ifdef CC_DEMUX_BROADCAST_EN
    input  logic                               CC_DEMUX_broadcast_In,
`endif
    output logic                               CC_DEMUX_ready_Out,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data0_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data1_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data2_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data3_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data4_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data5_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data6_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data7_OutBUS,
    output logic [(2**DATAWIDTH_MUX_SELECTION)-1:0] CC_DEMUX_valid_OutBUS,
    input  logic [(2**DATAWIDTH_MUX_SELECTION)-1:0] CC_DEMUX_ack_InBUS
);
    localparam int NUM_CH = 2**DATAWIDTH_MUX_SELECTION;

    logic [NUM_CH-1:0][DATAWIDTH_BUS-1:0] slotData;
    logic [NUM_CH-1:0]                    slotFull;
    logic [NUM_CH-1:0]                    canTake;
    logic [NUM_CH-1:0]                    load;
    logic [NUM_CH-1:0]                    target;
    logic                                 bcast;

`ifdef CC_DEMUX_BROADCAST_EN
    assign bcast = CC_DEMUX_broadcast_In;
`else
    assign bcast = 1'b0;
`endif

    // a slot can take a word if empty or being drained this same cycle
    assign canTake = ~slotFull | CC_DEMUX_ack_InBUS;

    always_comb begin
        target             = bcast ? '1 : (NUM_CH'(1) << CC_DEMUX_selection_InBUS);
        CC_DEMUX_ready_Out = bcast ? (&canTake) : canTake[CC_DEMUX_selection_InBUS];
        load               = (CC_DEMUX_valid_In && CC_DEMUX_ready_Out) ? target : '0;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : gSlot
        cc_demux_slot #(.W(DATAWIDTH_BUS)) uSlot (
            .clk     (CC_DEMUX_CLOCK_50),
            .rstN    (CC_DEMUX_RESET_InLow),
            .load    (load[k]),
            .ack     (CC_DEMUX_ack_InBUS[k]),
            .dataIn  (CC_DEMUX_data_InBUS),
            .dataOut (slotData[k]),
            .full    (slotFull[k])
        );
    end

    assign CC_DEMUX_valid_OutBUS = slotFull;
    assign CC_DEMUX_data0_OutBUS = slotData[0];
    assign CC_DEMUX_data1_OutBUS = slotData[1];
    assign CC_DEMUX_data2_OutBUS = slotData[2];
    assign CC_DEMUX_data3_OutBUS = slotData[3];
    assign CC_DEMUX_data4_OutBUS = slotData[4];
    assign CC_DEMUX_data5_OutBUS = slotData[5];
    assign CC_DEMUX_data6_OutBUS = slotData[6];
    assign CC_DEMUX_data7_OutBUS = slotData[7];
endmodule
